// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - BCD digit type and 7-segment glyph constants for seg_counter_mux
package seg_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational BCD to 7-segment decoder
module seg_decode
    import seg_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_counter_mux.sv
// rtl/seg_counter_mux.sv - prescaled BCD up/down counter with multiplexed 7-segment scan
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the highest non-zero digit.
module seg_counter_mux
    import seg_pkg::*;
#(
    parameter int               DIV_W   = 24,
    parameter logic [DIV_W-1:0] DIV_RST = 24'd999_999,
    parameter int               DIGITS  = 4,
    parameter int               SCAN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  div_load,
    input  logic [DIV_W-1:0]      div_val,
    output logic                  tick,
    output logic                  carry,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   count
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_pre_cnt;
    logic                r_tick;
    logic [4*DIGITS-1:0] r_count;
    logic                r_carry;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [DIGITS-1:0]   r_dig_sel;
    logic [6:0]          r_seg;

    logic [4*DIGITS-1:0] w_count_nxt;
    logic                w_wrap;
    logic [DIGITS-1:0]   w_onehot;
    bcd_t                w_digit;
    logic [6:0]          w_seg_dec;
    logic [6:0]          w_seg_out;

    // A load restarts the period immediately and swallows any expiry in that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= DIV_RST;
            r_pre_cnt <= DIV_RST;
            r_tick    <= 1'b0;
        end else if (div_load) begin
            r_div     <= div_val;
            r_pre_cnt <= div_val;
            r_tick    <= 1'b0;
        end else if (en && (r_pre_cnt == '0)) begin
            r_pre_cnt <= r_div;
            r_tick    <= 1'b1;
        end else begin
            if (en) begin
                r_pre_cnt <= r_pre_cnt - DIV_W'(1);
            end
            r_tick <= 1'b0;
        end
    end

    // Ripple chain: w_wrap doubles as the carry/borrow into each digit and ends as the wrap flag
    always_comb begin
        w_count_nxt = r_count;
        w_wrap      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_wrap) begin
                if (up_dn) begin
                    if (r_count[4*i +: 4] >= BCD_MAX) begin
                        w_count_nxt[4*i +: 4] = 4'd0;
                    end else begin
                        w_count_nxt[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                        w_wrap                = 1'b0;
                    end
                end else begin
                    if (r_count[4*i +: 4] == 4'd0) begin
                        w_count_nxt[4*i +: 4] = BCD_MAX;
                    end else begin
                        w_count_nxt[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                        w_wrap                = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else if (r_tick) begin
            r_count <= w_count_nxt;
            r_carry <= w_wrap;
        end else begin
            r_carry <= 1'b0;
        end
    end

    always_comb begin
        w_digit  = 4'd0;
        w_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit     = r_count[4*i +: 4];
                w_onehot[i] = 1'b1;
            end
        end
    end

    seg_decode u_seg_decode (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic w_blank;

    always_comb begin
        w_blank = (r_idx != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if ((IDX_W'(i) >= r_idx) && (r_count[4*i +: 4] != 4'd0)) begin
                w_blank = 1'b0;
            end
        end
    end

    assign w_seg_out = w_blank ? SEG_BLANK : w_seg_dec;
`else
    assign w_seg_out = w_seg_dec;
`endif

    // Scan runs regardless of en; dig_sel and seg are registered together so they never skew
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_dig_sel  <= DIGITS'(1);
            r_seg      <= SEG_BLANK;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            if (&r_scan_cnt) begin
                r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end
            r_dig_sel <= w_onehot;
            r_seg     <= w_seg_out;
        end
    end

    assign tick    = r_tick;
    assign carry   = r_carry;
    assign count   = r_count;
    assign dig_sel = r_dig_sel;
    assign seg     = r_seg;

endmodule

// File: tb/tb_seg_counter_mux.sv
// tb/tb_seg_counter_mux.sv - self-checking bench for seg_counter_mux against an integer reference model
module tb_seg_counter_mux;

    localparam int              DIV_W   = 8;
    localparam logic [DIV_W-1:0] DIV_RST = 8'd3;
    localparam int              DIGITS  = 4;
    localparam int              SCAN_W  = 2;
    localparam int              MODV    = 10 ** DIGITS;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic                 up_dn;
    logic                 clr;
    logic                 div_load;
    logic [DIV_W-1:0]     div_val;
    logic                 tick;
    logic                 carry;
    logic [6:0]           seg;
    logic [DIGITS-1:0]    dig_sel;
    logic [4*DIGITS-1:0]  count;

    int errors = 0;
    int checks = 0;

    int         m_div;
    int         m_rem;
    int         m_count;
    int         m_cycles;
    bit         m_tick;
    bit         m_carry;
    logic [6:0] m_seg;
    logic [3:0] m_dig;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg_counter_mux #(
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_RST),
        .DIGITS  (DIGITS),
        .SCAN_W  (SCAN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .div_load (div_load),
        .div_val  (div_val),
        .tick     (tick),
        .carry    (carry),
        .seg      (seg),
        .dig_sel  (dig_sel),
        .count    (count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] disp(input int v, input int idx);
        int p;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && v < p) return 7'h00;
`endif
        return seg_tab[(v / p) % 10];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("tick",    32'(tick),    32'(m_tick));
        chk("carry",   32'(carry),   32'(m_carry));
        chk("count",   32'(count),   32'(to_bcd(m_count)));
        chk("dig_sel", 32'(dig_sel), 32'(m_dig));
        chk("seg",     32'(seg),     32'(m_seg));
    endtask

    task automatic model_reset();
        m_div    = int'(DIV_RST);
        m_rem    = int'(DIV_RST);
        m_count  = 0;
        m_cycles = 0;
        m_tick   = 1'b0;
        m_carry  = 1'b0;
        m_seg    = 7'h00;
        m_dig    = 4'b0001;
    endtask

    // One clock of model and DUT; inputs must already be set
    task automatic step();
        int         idx;
        int         n_div, n_rem, n_count;
        bit         n_tick, n_carry;
        logic [3:0] n_dig;
        logic [6:0] n_seg;
        idx   = (m_cycles / (1 << SCAN_W)) % DIGITS;
        n_dig = 4'(1 << idx);
        n_seg = disp(m_count, idx);
        n_div = m_div;
        n_rem = m_rem;
        if (div_load) begin
            n_div  = int'(div_val);
            n_rem  = int'(div_val);
            n_tick = 1'b0;
        end else if (en && m_rem == 0) begin
            n_rem  = m_div;
            n_tick = 1'b1;
        end else begin
            if (en) n_rem = m_rem - 1;
            n_tick = 1'b0;
        end
        n_count = m_count;
        n_carry = 1'b0;
        if (clr) begin
            n_count = 0;
        end else if (m_tick) begin
            if (up_dn) begin
                n_carry = (m_count == MODV - 1);
                n_count = (m_count + 1) % MODV;
            end else begin
                n_carry = (m_count == 0);
                n_count = (m_count + MODV - 1) % MODV;
            end
        end
        @(posedge clk);
        #1;
        m_div    = n_div;
        m_rem    = n_rem;
        m_tick   = n_tick;
        m_count  = n_count;
        m_carry  = n_carry;
        m_dig    = n_dig;
        m_seg    = n_seg;
        m_cycles = m_cycles + 1;
        check_all();
    endtask

    task automatic load_div(input int v);
        div_load = 1'b1;
        div_val  = DIV_W'(v);
        step();
        div_load = 1'b0;
    endtask

    task automatic goto_count(input int target);
        bit ok;
        load_div(0);
        up_dn = 1'b1;
        en    = 1'b1;
        clr   = 1'b1;
        step();
        clr = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (m_count + int'(m_tick) == target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("goto_reached", 32'(ok), 32'd1);
        en = 1'b0;
        step();
        step();
    endtask

    initial begin
        bit ok;
        rst_n    = 1'b0;
        en       = 1'b1;
        up_dn    = 1'b1;
        clr      = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();

        // Release: tick every 4th cycle, first increment one cycle after the first tick
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) step();

        // Down wrap 0000 -> 9999, then up wrap 9999 -> 0000
        load_div(0);
        clr = 1'b1;
        step();
        clr   = 1'b0;
        up_dn = 1'b0;
        for (int i = 0; i < 3; i++) step();
        up_dn = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Load divisor 0 while pre_cnt is 2
        load_div(3);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_rem == 2) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("pre_cnt_two", 32'(ok), 32'd1);
        load_div(0);
        for (int i = 0; i < 6; i++) step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // clr coinciding with a tick
        en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_tick) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("tick_seen", 32'(ok), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            up_dn    = $urandom_range(0, 1) != 0;
            clr      = ($urandom_range(0, 29) == 0);
            div_load = ($urandom_range(0, 24) == 0);
            div_val  = DIV_W'($urandom_range(0, 3));
            step();
        end
        clr      = 1'b0;
        div_load = 1'b0;

        // Scan of 1207 across all digits
        goto_count(1207);
        for (int i = 0; i < 20; i++) step();

        // Asynchronous reset mid-count
        en    = 1'b1;
        up_dn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Leading-zero case
        goto_count(42);
        for (int i = 0; i < 20; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
